ddr_stream_writer: RTL

- AXI-style write master that sits directly upstream of the DDR controller/model port 0 and feeds it with frame data.
- Accepts a DW-wide pixel/word stream, buffers it in a FWFT FIFO, and writes one frame as INCR bursts on the shared address channel (atype=1 = write).
- It then drives the W channel and consumes B responses.
- Used by the video pipeline to land a frame at cfg_base_addr before readback.

---
 rtl/ddr_stream_pkg.sv | 27 ++
 rtl/stream_sync_fifo.sv | 57 +++++
 rtl/ddr_stream_writer.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/ddr_stream_pkg.sv
// Shared definitions for the DDR stream writer: FSM state encoding, AXI field
// constants and the beat-size helper.
package ddr_stream_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_FILL = 3'd1,
    S_ADDR = 3'd2,
    S_DATA = 3'd3,
    S_RESP = 3'd4
  } state_e;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic       ATYPE_WR    = 1'b1;
  localparam logic [1:0] LOCK_NORMAL = 2'b00;

  // AXI size code: log2 of the bytes per beat.
  function automatic logic [2:0] size_of(input int dw);
    logic [2:0] r_code;
    r_code = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if ((8 << i) == dw) r_code = 3'(i);
    end
    return r_code;
  endfunction

endpackage

// File: rtl/stream_sync_fifo.sv
// First-word-fall-through synchronous FIFO buffering stream beats ahead of the
// W channel. Head word is visible on o_dout whenever o_empty is low.
module stream_sync_fifo
  import ddr_stream_pkg::*;
#(
  parameter int DW         = 128,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_push,
  input  logic [DW-1:0]                 i_din,
  input  logic                          i_pop,
  output logic [DW-1:0]                 o_dout,
  output logic                          o_full,
  output logic                          o_empty,
  output logic [$clog2(FIFO_DEPTH):0]   o_count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DW-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_full  = (r_count == (AW+1)'(FIFO_DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rd_ptr];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/ddr_stream_writer.sv
// Frame writer: buffers a beat stream and lands it at cfg_base_addr as INCR
// write bursts, one outstanding at a time. DDR_STREAM_WRITER_STATS_EN adds stall/burst counters.
module ddr_stream_writer
  import ddr_stream_pkg::*;
#(
  parameter int         DW         = 128,
  parameter int         BURST_LEN  = 16,
  parameter int         FIFO_DEPTH = 64,
  parameter logic [7:0] AXI_ID     = 8'h00
) (
  input  logic            mem_clk,
  input  logic            resetn,
  input  logic [31:0]     cfg_base_addr,
  input  logic [23:0]     cfg_frame_beats,
  input  logic            start,
  output logic            busy,
  output logic            done,
  input  logic [DW-1:0]   s_tdata,
  input  logic            s_tvalid,
  output logic            s_tready,
  output logic [7:0]      aid,
  output logic [31:0]     aaddr,
  output logic [7:0]      alen,
  output logic [2:0]      asize,
  output logic [1:0]      aburst,
  output logic [1:0]      alock,
  output logic            avalid,
  input  logic            aready,
  output logic            atype,
  output logic [7:0]      wid,
  output logic [DW-1:0]   wdata,
  output logic [DW/8-1:0] wstrb,
  output logic            wlast,
  output logic            wvalid,
  input  logic            wready,
  input  logic [7:0]      bid,
  input  logic            bvalid,
  output logic            bready
`ifdef DDR_STREAM_WRITER_STATS_EN
  ,
  output logic [31:0]     stat_stall_cnt,
  output logic [15:0]     stat_burst_cnt
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_e        r_state;
  state_e        w_state_nxt;
  logic          r_busy;
  logic          r_done;
  logic          r_avalid;
  logic [31:0]   r_aaddr;
  logic [7:0]    r_alen;
  logic          r_wvalid;
  logic          r_bready;
  logic [31:0]   r_cur_addr;
  logic [23:0]   r_rem_beats;
  logic [7:0]    r_beat_cnt;
  logic [23:0]   w_burst_beats;
  logic          w_fill_ok;
  logic          w_a_hs;
  logic          w_w_hs;
  logic          w_b_hs;
  logic          w_wlast;
  logic          w_fifo_full;
  logic          w_fifo_empty;
  logic [CW-1:0] w_fifo_count;
  logic          w_unused;

  assign w_burst_beats = (r_rem_beats > 24'(BURST_LEN)) ? 24'(BURST_LEN) : r_rem_beats;
  assign w_fill_ok     = (24'(w_fifo_count) >= w_burst_beats);
  assign w_a_hs        = r_avalid && aready;
  assign w_w_hs        = r_wvalid && wready;
  assign w_b_hs        = r_bready && bvalid;
  assign w_wlast       = r_wvalid && (r_beat_cnt == 8'd0);
  assign w_unused      = ^{bid, w_fifo_empty};

  stream_sync_fifo #(
    .DW         (DW),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (mem_clk),
    .i_rst_n (resetn),
    .i_push  (s_tvalid && s_tready),
    .i_din   (s_tdata),
    .i_pop   (w_w_hs),
    .o_dout  (wdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  always_ff @(posedge mem_clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start)     w_state_nxt = S_FILL;
      S_FILL:  if (w_fill_ok) w_state_nxt = S_ADDR;
      S_ADDR:  if (w_a_hs)    w_state_nxt = S_DATA;
      S_DATA:  if (w_w_hs && w_wlast) w_state_nxt = S_RESP;
      S_RESP:  if (w_b_hs)    w_state_nxt = (r_rem_beats == 24'd0) ? S_IDLE : S_FILL;
      default:                w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge mem_clk or negedge resetn) begin
    if (!resetn) begin
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_avalid    <= 1'b0;
      r_aaddr     <= '0;
      r_alen      <= '0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_cur_addr  <= '0;
      r_rem_beats <= '0;
      r_beat_cnt  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          r_cur_addr  <= cfg_base_addr;
          r_rem_beats <= cfg_frame_beats;
          r_busy      <= 1'b1;
        end
        // The whole burst is already buffered, so W never starves.
        S_FILL: if (w_fill_ok) begin
          r_avalid <= 1'b1;
          r_aaddr  <= r_cur_addr;
          r_alen   <= 8'(w_burst_beats - 24'd1);
        end
        S_ADDR: if (w_a_hs) begin
          r_avalid   <= 1'b0;
          r_beat_cnt <= r_alen;
          r_wvalid   <= 1'b1;
        end
        S_DATA: if (w_w_hs) begin
          if (w_wlast) begin
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b1;
            r_cur_addr  <= r_cur_addr + 32'(w_burst_beats) * 32'(DW/8);
            r_rem_beats <= r_rem_beats - w_burst_beats;
          end else begin
            r_beat_cnt <= r_beat_cnt - 8'd1;
          end
        end
        S_RESP: if (w_b_hs) begin
          r_bready <= 1'b0;
          if (r_rem_beats == 24'd0) begin
            r_done <= 1'b1;
            r_busy <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign s_tready = r_busy && !w_fifo_full;
  assign aid      = AXI_ID;
  assign aaddr    = r_aaddr;
  assign alen     = r_alen;
  assign asize    = size_of(DW);
  assign aburst   = BURST_INCR;
  assign alock    = LOCK_NORMAL;
  assign avalid   = r_avalid;
  assign atype    = ATYPE_WR;
  assign wid      = AXI_ID;
  assign wstrb    = '1;
  assign wlast    = w_wlast;
  assign wvalid   = r_wvalid;
  assign bready   = r_bready;

`ifdef DDR_STREAM_WRITER_STATS_EN
  logic [31:0] r_stat_stall;
  logic [15:0] r_stat_burst;

  always_ff @(posedge mem_clk or negedge resetn) begin
    if (!resetn) begin
      r_stat_stall <= '0;
      r_stat_burst <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_stat_stall <= '0;
      r_stat_burst <= '0;
    end else begin
      if (r_busy && ((r_wvalid && !wready) || (r_avalid && !aready)))
        r_stat_stall <= r_stat_stall + 32'd1;
      if (w_b_hs) r_stat_burst <= r_stat_burst + 16'd1;
    end
  end

  assign stat_stall_cnt = r_stat_stall;
  assign stat_burst_cnt = r_stat_burst;
`endif

endmodule
